alarm_keypad_ctrl: RTL and testbench
====================================

# alarm_keypad_ctrl

Keypad front-end for the alarm controller. Collects digit keystrokes, checks them against a fixed PIN, and issues one-cycle arm or disarm request pulses to the alarm state machine. The current alarm state decides which request is issued. Repeated bad codes cause a timed lockout. It sits between the keypad scanner (`key_valid`/`key_code` strobes) and the alarm FSM's arm/disarm inputs.

## Interface
Parameters:
- `CODE_LEN`, default 4: number of PIN digits (1..8).
- `PIN`, default 16'h1234: expected code, 4 bits per digit, first-entered digit in the most significant nibble; width 4*CODE_LEN.
- `TIMEOUT_CYC`, default 200: idle cycles during entry before the partial entry is discarded.
- `MAX_FAILS`, default 3: consecutive bad codes that trigger lockout.
- `LOCKOUT_CYC`, default 500: lockout duration in cycles.

Ports:
- `clk` in 1: clock; single clock domain, all logic on the rising edge.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `ena` in 1: block enable; when low, all state holds and keys are ignored.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` in 4: 0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored.
- `alarm_state` in 2: alarm FSM state (00 OFF, 01 ARMED, 10 TRIGGERED, 11 ALARM_ON).
- `arm_req` out 1: one-cycle pulse, correct code entered while OFF.
- `disarm_req` out 1: one-cycle pulse, correct code entered while not OFF.
- `code_err` out 1: one-cycle pulse, rejected code.
- `lockout` out 1: high throughout LOCKOUT.
- `entry_active` out 1: high in ENTRY.
- `digit_cnt` out 4: digits held, saturating at CODE_LEN+1.

## Operation
- States: IDLE, ENTRY, CHECK, LOCKOUT.
- **IDLE**
  - A digit key loads the entry register, sets `digit_cnt` to 1 and moves to ENTRY.
  - CLEAR and ENTER are ignored (no error).
- **ENTRY**
  - Digit: entry register shifts left 4 and the new digit is placed in the low nibble; `digit_cnt` increments, saturating at CODE_LEN+1 (overflow marker); the timeout counter restarts.
  - CLEAR: entry register and `digit_cnt` go to 0, state goes to IDLE, fail count unchanged.
  - ENTER: go to CHECK.
  - 0xC-0xF: no effect, timeout counter not restarted.
  - Timeout counter reaches TIMEOUT_CYC with no accepted key: entry discarded, go to IDLE, no `code_err`, fail count unchanged.
- **CHECK** (exactly one cycle; keys ignored)
  - Match means `digit_cnt` == CODE_LEN and entry == PIN.
  - Match: pulse `arm_req` if `alarm_state` == OFF, otherwise pulse `disarm_req`; fail count goes to 0; go to IDLE.
  - Mismatch: pulse `code_err`; fail count increments. If the new count == MAX_FAILS, go to LOCKOUT, else go to IDLE.
  - Entry register and `digit_cnt` are cleared on leaving CHECK.
- **LOCKOUT**
  - All keys ignored; the lockout counter counts LOCKOUT_CYC cycles.
  - On expiry: fail count goes to 0, go to IDLE.
- `alarm_state` is sampled in the CHECK cycle only.
- `ena` = 0: FSM, counters and outputs hold. Pulse outputs are forced low and must not repeat.

## Timing
- Reset values: state IDLE, all outputs 0, entry register 0, fail count 0, both counters 0.
- ENTER sampled at edge k → CHECK during cycle k..k+1 → the result pulse is registered at edge k+1 and is high for exactly one cycle.
- `arm_req`, `disarm_req` and `code_err` are mutually exclusive and never high on consecutive cycles.
- `lockout` rises at the same edge as the `code_err` pulse that causes it, and stays high for LOCKOUT_CYC cycles.
- `entry_active` and `digit_cnt` are registered and update at the edge that samples the key.
- The timeout counter increments every enabled ENTRY cycle without an accepted key. The transition to IDLE happens on the edge where the count reaches TIMEOUT_CYC.
- A key arriving on that same edge wins: it is processed and the counter restarts.
- Reset asserted mid-entry or mid-lockout returns everything to reset values immediately.

## Test plan
- **Correct code while OFF.** Reset, `alarm_state` = 00, keys 1,2,3,4,ENTER → `arm_req` one cycle, 2 edges after ENTER; `digit_cnt` back to 0; no `code_err`.
- **Correct code while ARMED.** Same keys with `alarm_state` = 01 → `disarm_req` one pulse. Repeat with `alarm_state` = 11 → `disarm_req`.
- **Length errors.**
  - Keys 1,2,3,ENTER → `code_err`, fail count 1.
  - Keys 1,2,3,4,5,ENTER → `digit_cnt` reads 5 before ENTER, then `code_err`.
- **Lockout.**
  - Three bad codes (9,9,9,9,ENTER ×3) → `lockout` high for 500 cycles, and a correct code during it gives no pulse.
  - After lockout ends, 1,2,3,4,ENTER → `arm_req`.
- **Timeout and CLEAR.**
  - Keys 1,2 then 200 idle cycles → `entry_active` falls, no `code_err`.
  - Keys 1,2,CLEAR,1,2,3,4,ENTER → `arm_req`.
  - One bad code followed by a good code → fail count resets to 0.
- **Enable and reset.**
  - `ena` = 0 during 1,2,3,4,ENTER → no pulse, `digit_cnt` stays 0.
  - `rst_n` low in the middle of lockout → `lockout` = 0 asynchronously, IDLE.

Source files
------------

// File: rtl/alarm_keypad_ctrl.sv
// Keypad front-end: collects PIN digits, checks them, and issues arm/disarm/error pulses with a timed lockout.
// Latency: the result pulse is registered one edge after the edge that samples ENTER; status outputs update at the key edge.
// Backpressure: none; keys arriving while locked out, checking or disabled are dropped.
module alarm_keypad_ctrl #(
  parameter int                    CODE_LEN    = 4,
  parameter logic [4*CODE_LEN-1:0] PIN         = 16'h1234,
  parameter int                    TIMEOUT_CYC = 200,
  parameter int                    MAX_FAILS   = 3,
  parameter int                    LOCKOUT_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [1:0] alarm_state,
  output logic       arm_req,
  output logic       disarm_req,
  output logic       code_err,
  output logic       lockout,
  output logic       entry_active,
  output logic [3:0] digit_cnt
);

  localparam int EW = 4 * CODE_LEN;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYC);
  localparam logic [LW-1:0] LOCK_END = LW'(LOCKOUT_CYC);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
  localparam logic [3:0]    CNT_LEN  = 4'(CODE_LEN);
  localparam logic [3:0]    CNT_SAT  = 4'(CODE_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ENTRY   = 2'b01,
    ST_CHECK   = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [3:0]    digit_cnt_q, digit_cnt_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          arm_req_q, arm_req_d;
  logic          disarm_req_q, disarm_req_d;
  logic          code_err_q, code_err_d;
  logic          lockout_q, lockout_d;
  logic          entry_active_q, entry_active_d;

  logic          key_digit, key_clear, key_enter;
  logic          code_match;
  logic [TW-1:0] tmo_inc;
  logic [LW-1:0] lock_inc;
  logic [FW-1:0] fail_inc;

  // Key classification; codes 0xC-0xF fall through as "no accepted key".
  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clear = key_valid && (key_code == 4'hA);
  assign key_enter = key_valid && (key_code == 4'hB);

  // Overflowed entries keep digit_cnt at CODE_LEN+1, so the length test alone rejects them.
  assign code_match = (digit_cnt_q == CNT_LEN) && (entry_q == PIN);

  assign tmo_inc  = tmo_cnt_q + TW'(1);
  assign lock_inc = lock_cnt_q + LW'(1);
  assign fail_inc = fail_cnt_q + FW'(1);

  // Next-state, datapath and pulse generation; everything holds and pulses drop while ena is low.
  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digit_cnt_d  = digit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    arm_req_d    = 1'b0;
    disarm_req_d = 1'b0;
    code_err_d   = 1'b0;

    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (key_digit) begin
            entry_d     = EW'(key_code);
            digit_cnt_d = 4'd1;
            tmo_cnt_d   = '0;
            state_d     = ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (key_digit) begin
            // Shift-in keeps the most recent CODE_LEN digits, first digit ending in the top nibble.
            entry_d     = (entry_q << 4) | EW'(key_code);
            digit_cnt_d = (digit_cnt_q == CNT_SAT) ? digit_cnt_q : digit_cnt_q + 4'd1;
            tmo_cnt_d   = '0;
          end else if (key_clear) begin
            entry_d     = '0;
            digit_cnt_d = 4'd0;
            tmo_cnt_d   = '0;
            state_d     = ST_IDLE;
          end else if (key_enter) begin
            tmo_cnt_d = '0;
            state_d   = ST_CHECK;
          end else if (tmo_inc == TMO_END) begin
            // Silent abandon: no error pulse and the fail count is left alone.
            entry_d     = '0;
            digit_cnt_d = 4'd0;
            tmo_cnt_d   = '0;
            state_d     = ST_IDLE;
          end else begin
            tmo_cnt_d = tmo_inc;
          end
        end

        ST_CHECK: begin
          entry_d     = '0;
          digit_cnt_d = 4'd0;
          if (code_match) begin
            // alarm_state is only looked at here, in the single CHECK cycle.
            arm_req_d    = (alarm_state == 2'b00);
            disarm_req_d = (alarm_state != 2'b00);
            fail_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            code_err_d = 1'b1;
            fail_cnt_d = fail_inc;
            if (fail_inc == FAIL_MAX) begin
              lock_cnt_d = '0;
              state_d    = ST_LOCKOUT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_LOCKOUT: begin
          if (lock_inc == LOCK_END) begin
            lock_cnt_d = '0;
            fail_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            lock_cnt_d = lock_inc;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Level status outputs are registered decodes of the next state so they change on the key edge.
  always_comb begin
    lockout_d      = (state_d == ST_LOCKOUT);
    entry_active_d = (state_d == ST_ENTRY);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      entry_q        <= '0;
      digit_cnt_q    <= 4'd0;
      fail_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      lock_cnt_q     <= '0;
      arm_req_q      <= 1'b0;
      disarm_req_q   <= 1'b0;
      code_err_q     <= 1'b0;
      lockout_q      <= 1'b0;
      entry_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_q        <= entry_d;
      digit_cnt_q    <= digit_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      arm_req_q      <= arm_req_d;
      disarm_req_q   <= disarm_req_d;
      code_err_q     <= code_err_d;
      lockout_q      <= lockout_d;
      entry_active_q <= entry_active_d;
    end
  end

  assign arm_req      = arm_req_q;
  assign disarm_req   = disarm_req_q;
  assign code_err     = code_err_q;
  assign lockout      = lockout_q;
  assign entry_active = entry_active_q;
  assign digit_cnt    = digit_cnt_q;

endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// Bench for alarm_keypad_ctrl: scripted scenarios followed by randomized key traffic.
// Expected outputs per clock edge come from a digit-list reference model and are queued for a monitor.
// The monitor pops one expectation per edge and compares every DUT output.
module tb_alarm_keypad_ctrl;

  localparam int              CODE_LEN = 4;
  localparam logic [15:0]     PIN_V    = 16'h1234;
  localparam int              TIMEOUT  = 200;
  localparam int              MAXF     = 3;
  localparam int              LOCKC    = 500;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_CHECK = 2;
  localparam int M_LOCK  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] alarm_state = 2'd0;
  logic       arm_req, disarm_req, code_err, lockout, entry_active;
  logic [3:0] digit_cnt;

  alarm_keypad_ctrl #(
    .CODE_LEN(CODE_LEN), .PIN(PIN_V), .TIMEOUT_CYC(TIMEOUT),
    .MAX_FAILS(MAXF), .LOCKOUT_CYC(LOCKC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_valid(key_valid), .key_code(key_code),
    .alarm_state(alarm_state), .arm_req(arm_req), .disarm_req(disarm_req),
    .code_err(code_err), .lockout(lockout), .entry_active(entry_active), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       arm;
    logic       dis;
    logic       err;
    logic       lock;
    logic       ent;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: entered digits as a list, plus plain counters.
  int m_mode = M_IDLE;
  int m_digits[$];
  int m_fails = 0;
  int m_quiet = 0;
  int m_left = 0;
  int pin_digits[CODE_LEN];
  int cur_as = 0;
  bit as_wander = 0;

  function automatic bit code_ok();
    if (m_digits.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_digits[i] != pin_digits[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit kv, input int kc, input int as,
                            output exp_t e);
    e = '0;
    if (!r) begin
      m_mode = M_IDLE; m_digits.delete(); m_fails = 0; m_quiet = 0; m_left = 0;
    end else if (en) begin
      case (m_mode)
        M_IDLE: if (kv && kc <= 9) begin
          m_digits.delete(); m_digits.push_back(kc); m_mode = M_ENTRY; m_quiet = 0;
        end
        M_ENTRY: begin
          if (kv && kc <= 9) begin
            m_digits.push_back(kc); m_quiet = 0;
          end else if (kv && kc == 10) begin
            m_digits.delete(); m_mode = M_IDLE;
          end else if (kv && kc == 11) begin
            m_mode = M_CHECK;
          end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
              m_digits.delete(); m_mode = M_IDLE;
            end
          end
        end
        M_CHECK: begin
          if (code_ok()) begin
            e.arm = (as == 0); e.dis = (as != 0); m_fails = 0; m_mode = M_IDLE;
          end else begin
            e.err = 1'b1; m_fails++;
            if (m_fails == MAXF) begin
              m_mode = M_LOCK; m_left = LOCKC;
            end else begin
              m_mode = M_IDLE;
            end
          end
          m_digits.delete();
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_fails = 0; m_mode = M_IDLE;
          end
        end
      endcase
    end
    e.lock = (m_mode == M_LOCK);
    e.ent  = (m_mode == M_ENTRY);
    e.cnt  = (m_digits.size() > CODE_LEN) ? 4'(CODE_LEN + 1) : 4'(m_digits.size());
  endtask

  // One clock cycle of stimulus: drive at the falling edge, queue what the next rising edge must show.
  task automatic step(input bit r, input bit en, input bit kv, input int kc, input int as);
    exp_t e;
    @(negedge clk);
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      total++;
      if ({arm_req, disarm_req, code_err, lockout, entry_active, digit_cnt} != 9'd0) begin
        bad++;
        $display("FAIL async_reset t=%0t got arm=%b dis=%b err=%b lock=%b ent=%b cnt=%0d want all zero",
                 $time, arm_req, disarm_req, code_err, lockout, entry_active, digit_cnt);
      end
    end
    rst_n = r; ena = en; key_valid = kv; key_code = kc[3:0]; alarm_state = as[1:0];
    model_step(r, en, kv, kc, as, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1, 0, 0, cur_as);
  endtask

  task automatic key(input int kc);
    if (as_wander) cur_as = $urandom_range(0, 3);
    step(1, 1, 1, kc, cur_as);
  endtask

  // Random short gap, occasionally with ena low and a key that must be ignored.
  task automatic rgap();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      if (as_wander) cur_as = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) step(1, 0, $urandom_range(0, 1), $urandom_range(0, 15), cur_as);
      else step(1, 1, 0, 0, cur_as);
    end
  endtask

  task automatic enter_pin(input bit gaps);
    for (int i = 0; i < CODE_LEN; i++) begin
      key(pin_digits[i]);
      if (gaps) rgap();
    end
    key(11);
    if (gaps) rgap();
  endtask

  task automatic enter_bad();
    repeat (4) key(9);
    key(11);
    idle(1);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit after it.
  exp_t mon_e, mon_a;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {arm_req, disarm_req, code_err, lockout, entry_active, digit_cnt};
        total++;
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL edge_outputs t=%0t got arm=%b dis=%b err=%b lock=%b ent=%b cnt=%0d want arm=%b dis=%b err=%b lock=%b ent=%b cnt=%0d",
                   $time, mon_a.arm, mon_a.dis, mon_a.err, mon_a.lock, mon_a.ent, mon_a.cnt,
                   mon_e.arm, mon_e.dis, mon_e.err, mon_e.lock, mon_e.ent, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    int pv;
    int kind;
    int n;
    int wait_cyc;
    pv = PIN_V;
    for (int i = 0; i < CODE_LEN; i++) pin_digits[i] = (pv >> (4 * (CODE_LEN - 1 - i))) & 15;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({arm_req, disarm_req, code_err, lockout, entry_active, digit_cnt} != 9'd0) begin
      bad++;
      $display("FAIL reset_state got %b want all zero",
               {arm_req, disarm_req, code_err, lockout, entry_active, digit_cnt});
    end
    repeat (3) step(0, 1, 0, 0, 0);
    idle(2);

    // Correct code while OFF, ARMED and ALARM_ON.
    cur_as = 0; enter_pin(0); idle(3);
    cur_as = 1; enter_pin(0); idle(3);
    cur_as = 3; enter_pin(0); idle(3);

    // Length errors (two fails), then a good code clears the count.
    cur_as = 0;
    key(1); key(2); key(3); key(11); idle(2);
    key(1); key(2); key(3); key(4); key(5); key(11); idle(2);
    enter_pin(0); idle(2);

    // Three bad codes lock out; a correct code inside lockout is ignored; afterwards it works.
    enter_bad(); enter_bad(); enter_bad();
    idle(20); enter_pin(0);
    idle(LOCKC);
    enter_pin(0); idle(3);

    // Timeout discards partial entry; key exactly at the timeout edge wins.
    key(1); key(2); idle(TIMEOUT + 5);
    key(1); idle(TIMEOUT - 1); key(2); key(3); key(4); key(11); idle(3);
    key(1); key(2); key(10); enter_pin(0); idle(3);

    // Ena low during a whole entry.
    step(1, 0, 1, 1, 0); step(1, 0, 1, 2, 0); step(1, 0, 1, 3, 0);
    step(1, 0, 1, 4, 0); step(1, 0, 1, 11, 0); step(1, 0, 0, 0, 0);
    idle(2);

    // Ena dropped during the CHECK cycle delays the single result pulse.
    key(1); key(2); key(3); key(4); key(11);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); idle(3);

    // Reset in the middle of lockout.
    enter_bad(); enter_bad(); enter_bad();
    idle(100);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    idle(2); enter_pin(0); idle(3);

    // Randomized traffic.
    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 9);
      cur_as = $urandom_range(0, 3);
      as_wander = (kind == 9);
      case (kind)
        0, 1, 2, 3, 9: enter_pin(1);
        4, 5: begin
          n = $urandom_range(1, 6);
          repeat (n) begin key($urandom_range(0, 9)); rgap(); end
          key(11); rgap();
        end
        6: begin
          n = $urandom_range(1, 8);
          repeat (n) begin key($urandom_range(0, 15)); rgap(); end
        end
        7: begin
          n = $urandom_range(1, 5);
          repeat (n) begin key($urandom_range(0, 9)); rgap(); end
          key(10); rgap();
        end
        default: begin
          key($urandom_range(0, 9));
          idle(TIMEOUT - 1 + $urandom_range(0, 2));
          key($urandom_range(0, 9)); rgap();
        end
      endcase
      as_wander = 0;
    end
    idle(5);

    // Every queued expectation must have been consumed by the monitor.
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
